smac_sequencer: RTL and testbench
=================================

SMAC_SEQUENCER -- requirements
Module: smac_sequencer

Interface
REQ-001 SHALL have parameter ROWS, default 8: number of cascaded smac rows in the column being sequenced.
REQ-002 SHALL have parameter PIPE_LAT, default 3: internal DSP MAC pipeline latency in cycles.
REQ-003 SHALL have parameter K_W, default 16: width of the accumulation-length input.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a new accumulation job; sampled only in IDLE.
REQ-007 prec_mode  input  2  requested precision: 00=8b, 01=16b, 10=32b, 11=64b.
REQ-008 k_len  input  K_W  number of operand beats to accumulate.
REQ-009 data_valid  input  1  feeder presents a valid operand beat this cycle.
REQ-010 abort  input  1  cancel the current job.
REQ-011 data_ready  output  1  sequencer accepts the beat; a beat transfers when data_valid and data_ready are both high.
REQ-012 ce  output  1  clock enable to every smac.
REQ-013 sclr  output  1  synchronous clear to every smac.
REQ-014 select_precision  output  4  DSP-slice group enables to every smac.
REQ-015 active_chain  output  1  high while the chain holds live partial sums.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  single-cycle job-complete pulse.

Function
REQ-018 SHALL implement states IDLE, CLEAR, RUN, DRAIN, DONE.
REQ-019 IDLE: start=1 SHALL latch prec_mode and k_len and go to CLEAR next cycle; start=0 SHALL hold IDLE.
REQ-020 CLEAR SHALL last exactly 1 cycle with sclr=1 and ce=0; it SHALL go to DONE if the latched k_len=0, else to RUN.
REQ-021 RUN: data_ready=1; ce SHALL equal data_valid; each transfer SHALL increment the beat counter.
REQ-022 RUN SHALL go to DRAIN in the cycle after the k_len-th transfer; no beat SHALL be accepted beyond k_len.
REQ-023 data_valid=0 in RUN SHALL freeze ce, the counter, and all smac pipeline state (stall).
REQ-024 DRAIN SHALL hold ce=1 and data_ready=0 for exactly PIPE_LAT+2*(ROWS-1) cycles, then go to DONE.
REQ-025 DONE SHALL last 1 cycle with done=1 and ce=0, then go to IDLE.
REQ-026 select_precision SHALL decode the latched mode: 8b=0001, 16b=0011, 32b=0111, 64b=1111. It SHALL be 0000 in IDLE.
REQ-027 active_chain SHALL be 1 in RUN and DRAIN and 0 in all other states.
REQ-028 start while busy=1 SHALL be ignored, with no queuing.
REQ-029 abort=1 in any non-IDLE state SHALL force CLEAR-like behaviour for one cycle (sclr=1, ce=0), then IDLE with no done pulse; abort in IDLE SHALL be ignored.
REQ-030 abort and the k_len-th transfer in the same cycle: abort SHALL win.
REQ-031 The beat counter SHALL be K_W bits and SHALL never wrap; the maximum k_len is 2^K_W-1.
REQ-032 All outputs SHALL be registered or decoded only from the state register; there SHALL be no combinational path from inputs to outputs except ce and data_ready in RUN.

Reset
REQ-033 reset=1 SHALL asynchronously force IDLE, counters 0, ce=0, sclr=0, select_precision=0000, active_chain=0, busy=0, done=0, data_ready=0.
REQ-034 Reset deassertion mid-job SHALL leave the block in IDLE; the first job after reset SHALL still pass through CLEAR.

Configuration
REQ-035 With macro SMAC_SEQ_PERF_EN defined, the block SHALL add outputs stall_cnt (K_W) and run_cnt (K_W). These count RUN cycles with data_valid=0 and all RUN cycles, cleared in CLEAR and saturating at all-ones.
REQ-036 Without SMAC_SEQ_PERF_EN, these ports and their counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 start, prec_mode=01, k_len=4, data_valid held 1 -> sclr for 1 cycle; ce=1 for 4 RUN cycles plus 17 DRAIN cycles (defaults); select_precision=0011; done pulse at cycle 23 after start.
REQ-038 k_len=3 with data_valid pattern 1,0,0,1,1 -> exactly 3 transfers; ce follows data_valid; DRAIN entered after the 5th RUN cycle; stall_cnt=2 when SMAC_SEQ_PERF_EN is defined.
REQ-039 k_len=0, prec_mode=11 -> CLEAR then DONE; ce never asserted; done 2 cycles after start.
REQ-040 abort asserted at the 3rd DRAIN cycle -> next cycle sclr=1, ce=0; then IDLE; no done pulse; start asserted at that time is ignored.
REQ-041 reset pulsed asynchronously mid-RUN -> all outputs 0 immediately, without waiting for a clock edge; a new start runs a normal job.
REQ-042 start held high continuously across two jobs -> second job begins only after the DONE cycle, from IDLE.

Source files
------------

// File: rtl/smac_sequencer_if.sv
// smac_sequencer_if: job-control and smac-column control bundle between a feeder/controller and smac_sequencer
interface smac_sequencer_if #(
  parameter int K_W = 16
);
  logic           start;
  logic [1:0]     prec_mode;
  logic [K_W-1:0] k_len;
  logic           data_valid;
  logic           abort;
  logic           data_ready;
  logic           ce;
  logic           sclr;
  logic [3:0]     select_precision;
  logic           active_chain;
  logic           busy;
  logic           done;
  modport master (
    output start, prec_mode, k_len, data_valid, abort,
    input  data_ready, ce, sclr, select_precision, active_chain, busy, done
  );
  modport slave (
    input  start, prec_mode, k_len, data_valid, abort,
    output data_ready, ce, sclr, select_precision, active_chain, busy, done
  );
endinterface

// File: rtl/smac_sequencer.sv
// smac_sequencer: sequences a cascaded smac column through clear/run/drain/done; SMAC_SEQ_PERF_EN adds stall_cnt/run_cnt
module smac_sequencer #(
  parameter int ROWS     = 8,
  parameter int PIPE_LAT = 3,
  parameter int K_W      = 16
) (
  input  logic           clk,
  input  logic           reset,
`ifdef SMAC_SEQ_PERF_EN
  output logic [K_W-1:0] stall_cnt,
  output logic [K_W-1:0] run_cnt,
`endif
  smac_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE, ABRT} state_t;
  localparam int DRAIN_CYC = PIPE_LAT + 2 * (ROWS - 1);
  localparam int D_W = DRAIN_CYC > 1 ? $clog2(DRAIN_CYC) : 1;
  state_t         state, state_n;
  logic [K_W-1:0] cnt, k_lat;
  logic [1:0]     mode_lat;
  logic [D_W-1:0] dcnt;
  logic           xfer, last_beat, drain_end;
  logic [3:0]     sel;
  assign xfer      = state == RUN && bus.data_valid;
  assign last_beat = xfer && cnt == k_lat - K_W'(1);
  assign drain_end = dcnt == D_W'(DRAIN_CYC - 1);
  assign sel       = {mode_lat == 2'b11, mode_lat[1], |mode_lat, 1'b1};
  // state register; reset lands in IDLE asynchronously
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state; abort overrides everything outside IDLE, including the final beat
  always_comb begin
    state_n = state;
    if (bus.abort && state != IDLE && state != ABRT) state_n = ABRT;
    else
      case (state)
        IDLE:    state_n = bus.start ? CLEAR : IDLE;
        CLEAR:   state_n = k_lat == '0 ? DONE : RUN;
        RUN:     state_n = last_beat ? DRAIN : RUN;
        DRAIN:   state_n = drain_end ? DONE : DRAIN;
        default: state_n = IDLE;
      endcase
  end
  // outputs decode the state register; only ce follows data_valid, and only in RUN
  always_comb begin
    bus.data_ready       = state == RUN;
    bus.ce               = state == RUN ? bus.data_valid : state == DRAIN;
    bus.sclr             = state == CLEAR || state == ABRT;
    bus.select_precision = state == IDLE ? 4'b0000 : sel;
    bus.active_chain     = state == RUN || state == DRAIN;
    bus.busy             = state != IDLE;
    bus.done             = state == DONE;
  end
  // job latch, beat counter (bounded by k_len so it cannot wrap) and drain timer
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      k_lat    <= '0;
      mode_lat <= '0;
      cnt      <= '0;
      dcnt     <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        k_lat    <= bus.k_len;
        mode_lat <= bus.prec_mode;
      end
      cnt  <= state == CLEAR ? '0 : xfer ? cnt + K_W'(1) : cnt;
      dcnt <= state == DRAIN ? dcnt + D_W'(1) : '0;
    end
`ifdef SMAC_SEQ_PERF_EN
  // saturating RUN-cycle and stall-cycle counters, cleared at job start
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      run_cnt   <= '0;
      stall_cnt <= '0;
    end else if (state == CLEAR) begin
      run_cnt   <= '0;
      stall_cnt <= '0;
    end else if (state == RUN) begin
      run_cnt   <= run_cnt + K_W'(!(&run_cnt));
      stall_cnt <= stall_cnt + K_W'(!bus.data_valid && !(&stall_cnt));
    end
`endif
endmodule

// File: tb/tb_smac_sequencer.sv
// tb_smac_sequencer: directed scenarios for smac_sequencer at default parameters (drain = 3 + 2*7 = 17 cycles)
module tb_smac_sequencer;
  localparam int DR = 17;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  logic [15:0] stall_cnt, run_cnt;
  logic [9:0] obs;
  smac_sequencer_if #(.K_W(16)) bus ();
  smac_sequencer #(.ROWS(8), .PIPE_LAT(3), .K_W(16)) dut (
    .clk(clk),
    .reset(reset),
`ifdef SMAC_SEQ_PERF_EN
    .stall_cnt(stall_cnt),
    .run_cnt(run_cnt),
`endif
    .bus(bus)
  );
`ifndef SMAC_SEQ_PERF_EN
  assign stall_cnt = '0;
  assign run_cnt = '0;
`endif
  always #5 clk = ~clk;
  assign obs = {bus.data_ready, bus.ce, bus.sclr, bus.select_precision, bus.active_chain, bus.busy, bus.done};
  function automatic logic [9:0] pk(input int dr, input int ce, input int sc, input logic [3:0] sel, input int act, input int bz, input int dn);
    return {1'(dr), 1'(ce), 1'(sc), sel, 1'(act), 1'(bz), 1'(dn)};
  endfunction
  function automatic logic [9:0] exp_at(input int k, input logic [3:0] sel, input int t);
    if (t == 1) return pk(0, 0, 1, sel, 0, 1, 0);
    if (k == 0) return t == 2 ? pk(0, 0, 0, sel, 0, 1, 1) : '0;
    if (t <= k + 1) return pk(1, 1, 0, sel, 1, 1, 0);
    if (t <= k + 1 + DR) return pk(0, 1, 0, sel, 1, 1, 0);
    if (t == k + 2 + DR) return pk(0, 0, 0, sel, 0, 1, 1);
    return '0;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.start = 0; bus.prec_mode = 0; bus.k_len = 0; bus.data_valid = 0; bus.abort = 0;
    reset = 1;
    #2;
    checks++;
    if (obs !== 10'b0) begin errors++; $display("FAIL reset outputs got %b exp %b", obs, 10'b0); end
    tick();
    reset = 0;
    tick();
    checks++;
    if (obs !== 10'b0) begin errors++; $display("FAIL reset idle got %b exp %b", obs, 10'b0); end
  endtask
  task automatic test_job(input int k, input logic [1:0] prec, input logic [3:0] sel, input string name);
    bus.prec_mode = prec; bus.k_len = 16'(k); bus.data_valid = 1; bus.start = 1;
    #1;
    checks++;
    if (obs !== 10'b0) begin errors++; $display("FAIL %s start cycle got %b exp %b", name, obs, 10'b0); end
    for (int t = 1; t <= (k == 0 ? 3 : k + 3 + DR); t++) begin
      tick();
      bus.start = 0;
      #1;
      checks++;
      if (obs !== exp_at(k, sel, t)) begin errors++; $display("FAIL %s cycle %0d got %b exp %b", name, t, obs, exp_at(k, sel, t)); end
    end
    bus.data_valid = 0;
  endtask
  task automatic test_stall();
    logic [4:0] pat = 5'b11001;
    logic [9:0] e;
    int xf = 0;
    bus.prec_mode = 2'b00; bus.k_len = 3; bus.data_valid = 0; bus.start = 1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      bus.start = 0;
      bus.data_valid = c < 2 ? 1'b0 : c <= 6 ? pat[c-2] : 1'b1;
      #1;
      if (bus.data_valid && bus.data_ready) xf++;
      e = c == 1 ? pk(0, 0, 1, 4'b0001, 0, 1, 0) :
          c <= 6 ? pk(1, int'(pat[c-2]), 0, 4'b0001, 1, 1, 0) :
          c <= 23 ? pk(0, 1, 0, 4'b0001, 1, 1, 0) :
          c == 24 ? pk(0, 0, 0, 4'b0001, 0, 1, 1) : '0;
      checks++;
      if (obs !== e) begin errors++; $display("FAIL stall cycle %0d got %b exp %b", c, obs, e); end
    end
    bus.data_valid = 0;
    checks++;
    if (xf != 3) begin errors++; $display("FAIL stall transfers got %0d exp 3", xf); end
`ifdef SMAC_SEQ_PERF_EN
    checks++;
    if (stall_cnt !== 16'd2) begin errors++; $display("FAIL stall_cnt got %0d exp 2", stall_cnt); end
    checks++;
    if (run_cnt !== 16'd5) begin errors++; $display("FAIL run_cnt got %0d exp 5", run_cnt); end
`endif
  endtask
  task automatic test_abort();
    logic [9:0] e;
    bus.prec_mode = 2'b10; bus.k_len = 2; bus.data_valid = 1; bus.start = 1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      bus.start = c == 7;
      bus.abort = c == 6;
      #1;
      e = c == 7 ? pk(0, 0, 1, 4'b0111, 0, 1, 0) : c <= 6 ? exp_at(2, 4'b0111, c) : '0;
      checks++;
      if (obs !== e) begin errors++; $display("FAIL abort cycle %0d got %b exp %b", c, obs, e); end
    end
    bus.start = 0; bus.abort = 0; bus.data_valid = 0;
  endtask
  task automatic test_abort_last();
    logic [9:0] e;
    bus.prec_mode = 2'b00; bus.k_len = 1; bus.data_valid = 1; bus.start = 1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.start = 0;
      bus.abort = c == 2;
      #1;
      e = c == 1 ? pk(0, 0, 1, 4'b0001, 0, 1, 0) :
          c == 2 ? pk(1, 1, 0, 4'b0001, 1, 1, 0) :
          c == 3 ? pk(0, 0, 1, 4'b0001, 0, 1, 0) : '0;
      checks++;
      if (obs !== e) begin errors++; $display("FAIL abort_last cycle %0d got %b exp %b", c, obs, e); end
    end
    bus.abort = 0; bus.data_valid = 0;
  endtask
  task automatic test_async_reset();
    bus.prec_mode = 2'b01; bus.k_len = 4; bus.data_valid = 1; bus.start = 1;
    tick();
    bus.start = 0;
    tick();
    #1;
    checks++;
    if (obs !== pk(1, 1, 0, 4'b0011, 1, 1, 0)) begin errors++; $display("FAIL areset pre got %b exp %b", obs, pk(1, 1, 0, 4'b0011, 1, 1, 0)); end
    #2;
    reset = 1;
    #1;
    checks++;
    if (obs !== 10'b0) begin errors++; $display("FAIL areset immediate got %b exp %b", obs, 10'b0); end
    tick();
    reset = 0;
    bus.data_valid = 0;
    tick();
    test_job(1, 2'b00, 4'b0001, "after_reset");
  endtask
  task automatic test_back_to_back();
    int t;
    bus.prec_mode = 2'b00; bus.k_len = 1; bus.data_valid = 1; bus.start = 1;
    for (int c = 1; c <= 42; c++) begin
      tick();
      bus.start = c < 22;
      #1;
      t = c <= 21 ? c : c - 21;
      checks++;
      if (obs !== exp_at(1, 4'b0001, t)) begin errors++; $display("FAIL b2b cycle %0d got %b exp %b", c, obs, exp_at(1, 4'b0001, t)); end
    end
    bus.start = 0; bus.data_valid = 0;
  endtask
  initial begin
    test_reset();
    test_job(4, 2'b01, 4'b0011, "basic");
    test_stall();
    test_job(0, 2'b11, 4'b1111, "zero_len");
    test_abort();
    test_abort_last();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
